// File: rtl/regfile_pkg.sv
// Register file constants, types and index helper.
// Shared by the data array, scoreboard and interface.
package regfile_pkg;
  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int NUM_RD   = 2;
  localparam int ZERO_REG = 31;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int CNT_W    = $clog2(NUM_REGS + 1);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [CNT_W-1:0]  reg_cnt_t;

  // True for an index that names a real, writable register.
  function automatic logic addr_ok(reg_addr_t a);
    return (int'(a) != ZERO_REG) && (int'(a) < NUM_REGS);
  endfunction
endpackage

// File: rtl/regfile_fwd_if.sv
// ID/WB side bundle of the register file.
// Master drives reads, writeback and issue; slave answers.
interface regfile_fwd_if;
  import regfile_pkg::*;

  logic                   RegWrite;
  reg_addr_t              WriteRegister;
  reg_data_t              WriteData;
  reg_addr_t [NUM_RD-1:0] ReadRegister;
  reg_data_t [NUM_RD-1:0] ReadData;
  logic                   IssueValid;
  reg_addr_t              IssueDest;
  logic                   Flush;
  logic [NUM_RD-1:0]      ReadBusy;
  reg_cnt_t               PendingCount;

  modport master (
    output RegWrite, WriteRegister, WriteData,
    output ReadRegister, IssueValid, IssueDest, Flush,
    input  ReadData, ReadBusy, PendingCount
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData,
    input  ReadRegister, IssueValid, IssueDest, Flush,
    output ReadData, ReadBusy, PendingCount
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with issue/writeback/flush update,
// registered pending count and per-port busy lookup.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  reg_addr_t              issue_dest,
  input  logic                   flush,
  input  logic                   wr_en,
  input  reg_addr_t              wr_addr,
  input  reg_addr_t [NUM_RD-1:0] rd_addr,
  output logic [NUM_RD-1:0]      read_busy,
  output reg_cnt_t               pending_count
);
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  reg_cnt_t            cnt_d;

  // Issue beats writeback on the same register: newer writer wins.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (r == ZERO_REG) begin
        busy_d[r] = 1'b0;
      end else if (issue_valid && !flush &&
                   issue_dest == reg_addr_t'(r)) begin
        busy_d[r] = 1'b1;
      end else if (flush ||
                   (wr_en && wr_addr == reg_addr_t'(r))) begin
        busy_d[r] = 1'b0;
      end
      cnt_d = cnt_d + reg_cnt_t'(busy_d[r]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q        <= '0;
      pending_count <= '0;
    end else begin
      busy_q        <= busy_d;
      pending_count <= cnt_d;
    end
  end

  always_comb begin
    read_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      read_busy[p] = addr_ok(rd_addr[p]) &&
                     busy_q[rd_addr[p]] &&
                     !(wr_en && wr_addr == rd_addr[p]);
    end
  end
endmodule

// File: rtl/regfile_fwd.sv
// Register file with hardwired zero register, WB-to-ID
// bypass on every read port and a busy scoreboard.
module regfile_fwd
  import regfile_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  regfile_fwd_if.slave bus
);
  reg_data_t regs [NUM_REGS];
  logic      we;

  // Writeback is inert while reset is held so reads stay zero.
  assign we = bus.RegWrite && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else if (we && addr_ok(bus.WriteRegister)) begin
      regs[bus.WriteRegister] <= bus.WriteData;
    end
  end

  always_comb begin
    bus.ReadData = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (!addr_ok(bus.ReadRegister[p])) begin
        bus.ReadData[p] = '0;
      end else if (we &&
                   bus.WriteRegister == bus.ReadRegister[p]) begin
        bus.ReadData[p] = bus.WriteData;
      end else begin
        bus.ReadData[p] = regs[bus.ReadRegister[p]];
      end
    end
  end

  regfile_scoreboard u_sb (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (bus.IssueValid),
    .issue_dest   (bus.IssueDest),
    .flush        (bus.Flush),
    .wr_en        (we),
    .wr_addr      (bus.WriteRegister),
    .rd_addr      (bus.ReadRegister),
    .read_busy    (bus.ReadBusy),
    .pending_count(bus.PendingCount)
  );
endmodule

// File: tb/tb_regfile_fwd.sv
// Scoreboard bench for regfile_fwd: driver pushes expected
// outputs from an array model, monitor pops and compares.
module tb_regfile_fwd;
  import regfile_pkg::*;

  typedef struct {
    string       tag;
    logic [63:0] rd [2];
    logic [1:0]  rb;
    int          pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  regfile_fwd_if bus ();

  regfile_fwd dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [32];
  bit          busy [32];
  exp_t        q [$];
  event        drv_ev;
  int          checks = 0;
  int          errors = 0;

  function automatic int count_busy();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(busy[r]);
    return n;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 32; r++) begin
      mem[r]  = '0;
      busy[r] = 1'b0;
    end
  endfunction

  function automatic int pick();
    int r = $urandom_range(0, 9);
    if (r < 7) return r + 3;
    if (r == 7) return 31;
    return $urandom_range(0, 31);
  endfunction

  task automatic step(string tag, bit we, int wa,
                      logic [63:0] wd, int r0, int r1,
                      bit iv, int id, bit fl);
    exp_t e;
    int   ra;
    @(negedge clk);
    bus.RegWrite        = we;
    bus.WriteRegister   = reg_addr_t'(wa);
    bus.WriteData       = wd;
    bus.ReadRegister[0] = reg_addr_t'(r0);
    bus.ReadRegister[1] = reg_addr_t'(r1);
    bus.IssueValid      = iv;
    bus.IssueDest       = reg_addr_t'(id);
    bus.Flush           = fl;
    e.tag = tag;
    for (int p = 0; p < 2; p++) begin
      ra = (p == 0) ? r0 : r1;
      if (ra == 31) begin
        e.rd[p] = '0;
        e.rb[p] = 1'b0;
      end else if (we && wa == ra) begin
        e.rd[p] = wd;
        e.rb[p] = 1'b0;
      end else begin
        e.rd[p] = mem[ra];
        e.rb[p] = busy[ra];
      end
    end
    e.pc = count_busy();
    q.push_back(e);
    ->drv_ev;
    // state the edge will produce
    if (we && wa != 31) mem[wa] = wd;
    if (fl) begin
      for (int r = 0; r < 32; r++) busy[r] = 1'b0;
    end else begin
      if (we) busy[wa] = 1'b0;
      if (iv && id != 31) busy[id] = 1'b1;
    end
  endtask

  task automatic reset_step(string tag);
    exp_t e;
    @(negedge clk);
    reset               = 1'b0;
    bus.RegWrite        = 1'b0;
    bus.IssueValid      = 1'b0;
    bus.Flush           = 1'b0;
    bus.ReadRegister[0] = reg_addr_t'(pick());
    bus.ReadRegister[1] = reg_addr_t'(pick());
    model_clear();
    e.tag = tag;
    e.rd[0] = '0;
    e.rd[1] = '0;
    e.rb = '0;
    e.pc = 0;
    q.push_back(e);
    ->drv_ev;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic rand_step(string tag);
    step(tag, $urandom_range(0, 1) == 1, pick(),
         {$urandom, $urandom}, pick(), pick(),
         $urandom_range(0, 2) != 0, pick(),
         $urandom_range(0, 15) == 0);
  endtask

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(drv_ev);
      #2;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: got empty queue expected entry");
      end else begin
        e = q.pop_front();
        chk({e.tag, ".rd0"}, bus.ReadData[0], e.rd[0]);
        chk({e.tag, ".rd1"}, bus.ReadData[1], e.rd[1]);
        chk({e.tag, ".busy"}, 64'(bus.ReadBusy), 64'(e.rb));
        chk({e.tag, ".pend"}, 64'(bus.PendingCount),
            64'(e.pc));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    bus.RegWrite = 1'b0;
    bus.WriteRegister = '0;
    bus.WriteData = '0;
    bus.ReadRegister = '0;
    bus.IssueValid = 1'b0;
    bus.IssueDest = '0;
    bus.Flush = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    release_reset();
    step("rst",    0, 0, 0, 5, 7, 0, 0, 0);
    step("wr5",    1, 5, 64'hDEAD_BEEF_0000_0001,
         5, 31, 0, 0, 0);
    step("rd5",    0, 0, 0, 5, 5, 0, 0, 0);
    step("wr31",   1, 31, '1, 31, 5, 0, 0, 0);
    step("rd31",   0, 0, 0, 31, 31, 0, 0, 0);
    step("iss7",   0, 0, 0, 7, 7, 1, 7, 0);
    step("byp7",   1, 7, 64'h1234, 5, 7, 0, 0, 0);
    step("iss3",   0, 0, 0, 7, 3, 1, 3, 0);
    step("iss4",   0, 0, 0, 3, 4, 1, 4, 0);
    step("wbiss3", 1, 3, 64'h33, 3, 4, 1, 3, 0);
    step("keep3",  0, 0, 0, 3, 4, 1, 9, 0);
    step("flush",  1, 9, 64'h5, 9, 3, 1, 10, 1);
    step("post",   0, 0, 0, 9, 10, 0, 0, 0);
    step("iss31",  0, 0, 0, 31, 9, 1, 31, 0);
    step("post31", 0, 0, 0, 31, 4, 0, 0, 0);
    for (int i = 0; i < 300; i++) rand_step("rand");
    reset_step("arst");
    reset_step("arst2");
    release_reset();
    step("rel", 0, 0, 0, 5, 9, 0, 0, 0);
    for (int i = 0; i < 150; i++) rand_step("rand2");
    @(negedge clk);
    #20;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d left expected 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
